ahb_fb_writer: RTL
==================

// Module: ahb_fb_writer
// PURPOSE
//   AHB-Lite slave on the EMPU AHB2 master port that lets the MCU write the 160x120x3b game
//   framebuffer. It is the write side of the framebuffer the HDMI path reads and upscales 4x.
//   Supports single-pixel writes with an auto-increment cursor, 10-pixel packed bursts and a
//   hardware fill engine. It drives a simple single-port RAM write port.
// PARAMETERS
//   FB_WIDTH   160   framebuffer columns
//   FB_HEIGHT  120   framebuffer rows; FB_DEPTH = FB_WIDTH*FB_HEIGHT = 19200
//   PIX_BITS   3     bits per pixel (RGB 1:1:1)
//   ADDR_BITS  15    framebuffer address width; must satisfy 2**ADDR_BITS >= FB_DEPTH
//   PACK_N     10    pixels per PACK word; PACK_N*PIX_BITS <= 32
// PORTS
//   sys_clk        in   1          single clock (MCU/AHB clock)
//   sys_resetn     in   1          synchronous, active-low reset
//   ahb_hsel       in   1          slave select
//   ahb_haddr      in   12         byte address; only [4:2] decoded
//   ahb_htrans     in   2          NONSEQ/SEQ when bit1=1
//   ahb_hwrite     in   1          1 = write
//   ahb_hwdata     in   32         write data, data phase
//   ahb_hrdata     out  32         read data, valid in data phase when ahb_hreadyout=1
//   ahb_hreadyout  out  1          0 = wait state inserted
//   ahb_hresp      out  1          always 0 (OKAY)
//   fb_we          out  1          RAM write enable, one pixel per cycle
//   fb_addr        out  ADDR_BITS  RAM write address
//   fb_din         out  PIX_BITS   RAM write data
//   busy           out  1          PACK or FILL engine active
// BEHAVIOUR
//   Reset: hreadyout=1, hresp=0, hrdata=0, fb_we=0, fb_addr=0, fb_din=0, busy=0,
//     cursor=0, engine=IDLE.
//   Address phase is accepted when hsel & htrans[1] & hreadyout. Register haddr[4:2] and hwrite.
//     The data phase is the next cycle. hsize is ignored; all registers are word-wide.
//   Register map (offset):
//     0x00 CURSOR  RW  [14:0] next pixel address. A write value >= FB_DEPTH loads 0.
//                      A read returns {17'b0, cursor}.
//     0x04 PIXEL   W   writes hwdata[2:0] at cursor; cursor <= (cursor==FB_DEPTH-1) ? 0 : cursor+1.
//     0x08 PACK    W   pixel i = hwdata[3i+2:3i], i = 0..9. Written to cursor+i, one per cycle,
//                      addresses wrap at FB_DEPTH. Cursor ends at cursor+10 (mod FB_DEPTH).
//     0x0C FILL    W   writes hwdata[2:0] to addresses 0..FB_DEPTH-1, one per cycle.
//                      Cursor = 0 when done.
//     0x10 STATUS  R   bit0 = busy, bits[30:16] = engine address; other bits 0.
//     Other offsets: writes ignored, reads return 0, OKAY, zero wait.
//   fb_* outputs are registered. fb_we pulses the cycle after the completing data-phase cycle.
//   Engine FSM:
//     IDLE -> PACK when a PACK write completes. PACK_N cycles of fb_we, then IDLE.
//     IDLE -> FILL when a FILL write completes. FB_DEPTH cycles of fb_we, then IDLE.
//     busy = (state != IDLE), registered, and asserted in the same cycle as the first engine fb_we.
//   Wait states:
//     A data phase for any register other than STATUS that arrives while busy holds
//       hreadyout=0 until the cycle after the engine returns to IDLE.
//     The transfer then completes normally.
//     STATUS and unmapped reads always complete with zero wait, even while busy.
//   Back-to-back PIXEL writes while IDLE sustain one pixel per cycle with zero wait.
//   Reset asserted mid-engine: aborts immediately, fb_we=0 on the next cycle, all state as
//     at reset. RAM contents are left partially written.
// TESTING
//   1. CURSOR<=5; PIXEL 3'b101 x3 -> fb_we at addr 5,6,7 with din 5; CURSOR reads 8.
//   2. CURSOR<=19199; PIXEL 1, PIXEL 2 -> writes at 19199 then 0; CURSOR reads 1.
//   3. CURSOR<=19195; PACK 0x3FFFFFFF -> 10 writes din 7 at addr 19195..19199,0..4; busy high
//      for 10 cycles; CURSOR reads 5.
//   4. FILL 3'b010, then immediate PIXEL write -> 19200 writes din 2; the PIXEL data phase waits
//      with hreadyout=0 until fill ends, then writes addr 0.
//   5. FILL running, STATUS read -> zero-wait, bit0=1, bits[30:16] increasing across polls.
//   6. sys_resetn low for 1 cycle at fill address 1000 -> fb_we=0 next cycle, busy=0, CURSOR
//      reads 0, hreadyout=1.

Source files
------------

// File: rtl/ahb_fb_writer.sv
// AHB-Lite write port for the 160x120x3b game framebuffer: cursor-addressed pixel writes,
// packed 10-pixel bursts and a full-screen fill engine driving a single-port RAM write port.
module ahb_fb_writer #(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int PIX_BITS  = 3,
    parameter int ADDR_BITS = 15,
    parameter int PACK_N    = 10
) (
    input  logic                 sys_clk,
    input  logic                 sys_resetn,
    input  logic                 ahb_hsel,
    input  logic [11:0]          ahb_haddr,
    input  logic [1:0]           ahb_htrans,
    input  logic                 ahb_hwrite,
    input  logic [31:0]          ahb_hwdata,
    output logic [31:0]          ahb_hrdata,
    output logic                 ahb_hreadyout,
    output logic                 ahb_hresp,
    output logic                 fb_we,
    output logic [ADDR_BITS-1:0] fb_addr,
    output logic [PIX_BITS-1:0]  fb_din,
    output logic                 busy
);
    localparam int FB_DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int CNT_BITS = $clog2(PACK_N + 1);
    localparam logic [2:0] REG_CURSOR = 3'd0;
    localparam logic [2:0] REG_PIXEL  = 3'd1;
    localparam logic [2:0] REG_PACK   = 3'd2;
    localparam logic [2:0] REG_FILL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FB_DEPTH - 1);
    localparam logic [CNT_BITS-1:0]  CNT_LAST  = CNT_BITS'(PACK_N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    // Framebuffer addresses wrap at FB_DEPTH, not at the power of two.
    function automatic logic [ADDR_BITS-1:0] f_wrap_add(input logic [ADDR_BITS-1:0] base,
                                                        input int unsigned step);
        logic [ADDR_BITS:0] sum;
        sum = {1'b0, base} + (ADDR_BITS+1)'(step);
        if (sum >= (ADDR_BITS+1)'(FB_DEPTH)) begin
            sum = sum - (ADDR_BITS+1)'(FB_DEPTH);
        end else begin
            sum = sum;
        end
        return sum[ADDR_BITS-1:0];
    endfunction

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_busy;
    logic                  r_dp_valid;
    logic                  r_dp_write;
    logic [2:0]            r_dp_reg;
    logic [ADDR_BITS-1:0]  r_cursor;
    logic                  r_fb_we;
    logic [ADDR_BITS-1:0]  r_fb_addr;
    logic [PIX_BITS-1:0]   r_fb_din;
    logic [31:0]           r_pack;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  w_stall;
    logic                  w_accept;
    logic                  w_wr_done;
    logic [ADDR_BITS-1:0]  w_cursor_load;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    // Only mapped registers wait on the engine; STATUS and unmapped offsets never stall.
    assign w_stall       = r_dp_valid & (r_dp_reg < REG_STATUS) & r_busy;
    assign w_accept      = ahb_hsel & ahb_htrans[1] & ahb_hreadyout;
    assign w_wr_done     = r_dp_valid & r_dp_write & ~w_stall;
    assign w_cursor_load = (ahb_hwdata >= 32'(FB_DEPTH)) ? '0 : ahb_hwdata[ADDR_BITS-1:0];
    assign w_unused      = ^{ahb_haddr[11:5], ahb_haddr[1:0], ahb_htrans[0]};

    assign ahb_hreadyout = ~w_stall;
    assign ahb_hresp     = 1'b0;
    assign ahb_hrdata    = w_rdata;
    assign fb_we         = r_fb_we;
    assign fb_addr       = r_fb_addr;
    assign fb_din        = r_fb_din;
    assign busy          = r_busy;

    // Address-phase capture; held while the current data phase is stalled.
    always_ff @(posedge sys_clk) begin
        if (!sys_resetn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_reg   <= 3'd0;
        end else if (ahb_hreadyout) begin
            r_dp_valid <= w_accept;
            r_dp_write <= ahb_hwrite;
            r_dp_reg   <= ahb_haddr[4:2];
        end else begin
            r_dp_valid <= r_dp_valid;
            r_dp_write <= r_dp_write;
            r_dp_reg   <= r_dp_reg;
        end
    end

    // Read mux for the data phase.
    always_comb begin
        w_rdata = 32'd0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_reg)
                REG_CURSOR: w_rdata[ADDR_BITS-1:0] = r_cursor;
                REG_STATUS: begin
                    w_rdata[0]              = r_busy;
                    w_rdata[16 +: ADDR_BITS] = r_fb_addr;
                end
                default:    w_rdata = 32'd0;
            endcase
        end else begin
            w_rdata = 32'd0;
        end
    end

    // Engine state register; busy follows the next state so it rises with the first engine write.
    always_ff @(posedge sys_clk) begin
        if (!sys_resetn) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
        end
    end

    // Engine next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_done && r_dp_reg == REG_PACK) begin
                    w_state_next = ST_PACK;
                end else if (w_wr_done && r_dp_reg == REG_FILL) begin
                    w_state_next = ST_FILL;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_PACK: w_state_next = (r_cnt == CNT_LAST) ? ST_IDLE : ST_PACK;
            ST_FILL: w_state_next = (r_fb_addr == LAST_ADDR) ? ST_IDLE : ST_FILL;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Cursor and RAM write port; r_cnt counts pixels already issued in the current PACK.
    always_ff @(posedge sys_clk) begin
        if (!sys_resetn) begin
            r_cursor  <= '0;
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_din  <= '0;
            r_pack    <= 32'd0;
            r_cnt     <= '0;
        end else begin
            r_fb_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_done) begin
                        case (r_dp_reg)
                            REG_CURSOR: r_cursor <= w_cursor_load;
                            REG_PIXEL: begin
                                r_fb_we   <= 1'b1;
                                r_fb_addr <= r_cursor;
                                r_fb_din  <= ahb_hwdata[PIX_BITS-1:0];
                                r_cursor  <= f_wrap_add(r_cursor, 1);
                            end
                            REG_PACK: begin
                                r_fb_we   <= 1'b1;
                                r_fb_addr <= r_cursor;
                                r_fb_din  <= ahb_hwdata[PIX_BITS-1:0];
                                r_pack    <= ahb_hwdata >> PIX_BITS;
                                r_cnt     <= CNT_BITS'(1);
                                r_cursor  <= f_wrap_add(r_cursor, PACK_N);
                            end
                            REG_FILL: begin
                                r_fb_we   <= 1'b1;
                                r_fb_addr <= '0;
                                r_fb_din  <= ahb_hwdata[PIX_BITS-1:0];
                            end
                            default: r_cursor <= r_cursor;
                        endcase
                    end else begin
                        r_cursor <= r_cursor;
                    end
                end
                ST_PACK: begin
                    if (r_cnt != CNT_LAST) begin
                        r_fb_we   <= 1'b1;
                        r_fb_addr <= f_wrap_add(r_fb_addr, 1);
                        r_fb_din  <= r_pack[PIX_BITS-1:0];
                        r_pack    <= r_pack >> PIX_BITS;
                        r_cnt     <= r_cnt + CNT_BITS'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    if (r_fb_addr != LAST_ADDR) begin
                        r_fb_we   <= 1'b1;
                        r_fb_addr <= r_fb_addr + ADDR_BITS'(1);
                    end else begin
                        r_cursor <= '0;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end
endmodule
